lisnoc_router_arbiter_prio_age: RTL and testbench



---
 rtl/lisnoc_router_arbiter_prio_age.sv | 144 ++++++++++++++
 tb/tb_lisnoc_router_arbiter_prio_age.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lisnoc_router_arbiter_prio_age.sv
// Output-port arbiter: priority + aging score with round-robin tie-break and a wormhole lock.
// One-cycle registered output slice; the slice refills on the cycle it drains, so read_o stays 0 only while it is full and stalled.
module lisnoc_router_arbiter_prio_age #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ph_prio_width   = 4,
  parameter int ph_prio_offset  = 0,
  parameter int ports           = 5,
  parameter int age_width       = 3,
  parameter int aging_mode      = 1
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic [(flit_data_width+flit_type_width)*ports-1:0] flit_i,
  input  logic [ports-1:0]                                   request_i,
  output logic [ports-1:0]                                   read_o,
  output logic [flit_data_width+flit_type_width-1:0]         flit_o,
  output logic                                               valid_o,
  input  logic                                               ready_i,
  output logic [ports-1:0]                                   lock_o
);

  localparam int FW = flit_data_width + flit_type_width;
  localparam int SW = (aging_mode == 1) ? ph_prio_width : ph_prio_width + age_width;
  localparam int IW = (ports > 1) ? $clog2(ports) : 1;

  localparam logic [flit_type_width-1:0] TYPE_HEADER = flit_type_width'(1);
  localparam logic [flit_type_width-1:0] TYPE_LAST   = flit_type_width'(2);
  localparam logic [flit_type_width-1:0] TYPE_SINGLE = flit_type_width'(3);

  logic [FW-1:0]              w_flit  [ports];
  logic [flit_type_width-1:0] w_type  [ports];
  logic [SW-1:0]              w_score [ports];
  logic [age_width-1:0]       r_age   [ports];

  logic [IW-1:0]              r_rr;
  logic [ports-1:0]           r_lock;
  logic [FW-1:0]              r_flit;
  logic                       r_valid;

  logic [IW-1:0]              w_lock_idx;
  logic [IW-1:0]              w_scan;
  logic [IW-1:0]              w_idx;
  logic [IW-1:0]              w_gnt;
  logic [SW-1:0]              w_best;
  logic                       w_found;
  logic                       w_locked;
  logic                       w_gnt_vld;
  logic                       w_xfer;
  logic [flit_type_width-1:0] w_gtype;
  int                         w_pos;

  for (genvar p = 0; p < ports; p++) begin : g_port
    logic [ph_prio_width-1:0] w_field;
    logic [ph_prio_width-1:0] w_eff;
    logic                     w_prio_type;

    assign w_flit[p]   = flit_i[p*FW +: FW];
    assign w_type[p]   = w_flit[p][FW-1 -: flit_type_width];
    assign w_field     = w_flit[p][flit_data_width-ph_prio_offset-1 -: ph_prio_width];
    assign w_prio_type = (w_type[p] == TYPE_HEADER) || (w_type[p] == TYPE_SINGLE);
    // Payload/last flits and headers with the enable bit clear compete at priority 0.
    assign w_eff       = (w_prio_type && w_field[ph_prio_width-1]) ? w_field : '0;

    if (aging_mode == 1) begin : g_add
      localparam int SUMW = ((ph_prio_width > age_width) ? ph_prio_width : age_width) + 1;
      logic [SUMW-1:0] w_sum;
      assign w_sum      = SUMW'(w_eff) + SUMW'(r_age[p]);
      assign w_score[p] = (w_sum > SUMW'({ph_prio_width{1'b1}})) ?
                          {ph_prio_width{1'b1}} : w_sum[ph_prio_width-1:0];
    end else begin : g_cat
      assign w_score[p] = {w_eff, r_age[p]};
    end
  end

  // Cyclic scan starting just after the RR pointer; strict '>' keeps the first tied port.
  always_comb begin
    w_lock_idx = '0;
    for (int p = 0; p < ports; p++) begin
      if (r_lock[p]) w_lock_idx = IW'(p);
    end
    w_found = 1'b0;
    w_best  = '0;
    w_scan  = '0;
    w_pos   = 0;
    w_idx   = '0;
    for (int k = 1; k <= ports; k++) begin
      w_pos = int'(r_rr) + k;
      if (w_pos >= ports) w_pos = w_pos - ports;
      w_idx = IW'(w_pos);
      if (request_i[w_idx] && (!w_found || (w_score[w_idx] > w_best))) begin
        w_found = 1'b1;
        w_best  = w_score[w_idx];
        w_scan  = w_idx;
      end
    end
  end

  always_comb begin
    w_locked  = |r_lock;
    w_gnt     = w_locked ? w_lock_idx : w_scan;
    w_gnt_vld = w_locked ? request_i[w_lock_idx] : w_found;
    w_xfer    = rst_n && (!r_valid || ready_i) && w_gnt_vld;
    w_gtype   = w_type[w_gnt];
    read_o    = '0;
    if (w_xfer) read_o[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_flit  <= '0;
      r_lock  <= '0;
      r_rr    <= IW'(ports - 1);
      for (int p = 0; p < ports; p++) r_age[p] <= '0;
    end else begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_flit  <= w_flit[w_gnt];
      end else if (ready_i) begin
        r_valid <= 1'b0;
      end

      if (w_xfer) begin
        if (w_locked) begin
          if (w_gtype == TYPE_LAST) r_lock <= '0;
        end else begin
          if (w_gtype == TYPE_HEADER) r_lock <= read_o;
          if ((w_gtype == TYPE_HEADER) || (w_gtype == TYPE_SINGLE)) r_rr <= w_gnt;
          for (int p = 0; p < ports; p++) begin
            if (IW'(p) == w_gnt)         r_age[p] <= '0;
            else if (!request_i[p])      r_age[p] <= '0;
            else if (r_age[p] != {age_width{1'b1}}) r_age[p] <= r_age[p] + age_width'(1);
          end
        end
      end
    end
  end

  assign flit_o  = r_flit;
  assign valid_o = r_valid;
  assign lock_o  = r_lock;

endmodule

// File: tb/tb_lisnoc_router_arbiter_prio_age.sv
// Bench for the priority/age output arbiter: directed vector table, hand sequences and a random run against a reference model.
module tb_lisnoc_router_arbiter_prio_age;

  localparam int P  = 5;
  localparam int FW = 34;
  localparam logic [1:0] T_PAY = 2'b00, T_HDR = 2'b01, T_LAST = 2'b10, T_SGL = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [FW-1:0]   in_flit [P];
  logic [FW*P-1:0] flit_i;
  logic [P-1:0]    request_i, read_o, lock_o;
  logic [FW-1:0]   flit_o;
  logic            valid_o, ready_i;

  logic [FW-1:0]   in_flit0 [P];
  logic [FW*P-1:0] flit0_i;
  logic [P-1:0]    req0, read0, lock0;
  logic [FW-1:0]   flit0_o;
  logic            valid0, ready0;

  always #5 clk = ~clk;

  always_comb begin
    flit_i  = '0;
    flit0_i = '0;
    for (int p = 0; p < P; p++) begin
      flit_i[p*FW +: FW]  = in_flit[p];
      flit0_i[p*FW +: FW] = in_flit0[p];
    end
  end

  lisnoc_router_arbiter_prio_age #(.aging_mode(1)) dut (
    .clk(clk), .rst_n(rst_n), .flit_i(flit_i), .request_i(request_i), .read_o(read_o),
    .flit_o(flit_o), .valid_o(valid_o), .ready_i(ready_i), .lock_o(lock_o));

  lisnoc_router_arbiter_prio_age #(.aging_mode(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flit_i(flit0_i), .request_i(req0), .read_o(read0),
    .flit_o(flit0_o), .valid_o(valid0), .ready_i(ready0), .lock_o(lock0));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit            m_valid;
  logic [FW-1:0] m_flit;
  int            m_lock;
  int            m_rr;
  int            m_age [P];
  logic [P-1:0]  last_read;

  typedef struct {
    bit           do_rst;
    logic [P-1:0] req;
    logic [1:0]   typ;
    logic [4*P-1:0] fld;
    logic         rdy;
    logic [P-1:0] e_read;
    logic         e_valid;
    int           e_src;
  } vec_t;
  vec_t tbl [17];

  function automatic logic [FW-1:0] mk(logic [1:0] t, logic [3:0] f, int tag);
    return {t, f, 28'(tag)};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int m_score(int p);
    logic [1:0] t;
    logic [3:0] f;
    int e, s;
    t = in_flit[p][33:32];
    f = in_flit[p][31:28];
    e = ((t == T_HDR || t == T_SGL) && f[3]) ? int'(f) : 0;
    s = e + m_age[p];
    return (s > 15) ? 15 : s;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_flit = '0; m_lock = -1; m_rr = P - 1;
    for (int p = 0; p < P; p++) m_age[p] = 0;
  endtask

  // Highest score wins; among equals, the port at the smallest cyclic distance after the pointer.
  task automatic model_arb(output int g, output bit x);
    int best, bestd, d;
    g = -1; x = 1'b0; best = -1; bestd = P;
    if (m_valid && !ready_i) return;
    if (m_lock >= 0) begin
      g = m_lock; x = request_i[m_lock];
      return;
    end
    for (int p = 0; p < P; p++)
      if (request_i[p] && m_score(p) > best) best = m_score(p);
    for (int p = 0; p < P; p++) begin
      d = (p - m_rr - 1 + 2*P) % P;
      if (request_i[p] && m_score(p) == best && d < bestd) begin
        bestd = d; g = p;
      end
    end
    x = (g >= 0);
  endtask

  task automatic model_commit(int g, bit x);
    logic [1:0] t;
    if (x) begin
      t = in_flit[g][33:32];
      if (m_lock < 0) begin
        for (int p = 0; p < P; p++) begin
          if (p == g)             m_age[p] = 0;
          else if (request_i[p])  m_age[p] = (m_age[p] >= 7) ? 7 : m_age[p] + 1;
          else                    m_age[p] = 0;
        end
        if (t == T_HDR) m_lock = g;
        if (t == T_HDR || t == T_SGL) m_rr = g;
      end else if (t == T_LAST) begin
        m_lock = -1;
      end
      m_flit = in_flit[g]; m_valid = 1'b1;
    end else if (ready_i) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle(bit chk_age);
    int g;
    bit x;
    logic [P-1:0] er, el;
    @(negedge clk);
    model_arb(g, x);
    er = '0; if (x) er[g] = 1'b1;
    el = '0; if (m_lock >= 0) el[m_lock] = 1'b1;
    chk("read_o", 64'(read_o), 64'(er));
    chk("valid_o", 64'(valid_o), 64'(m_valid));
    if (m_valid) chk("flit_o", 64'(flit_o), 64'(m_flit));
    chk("lock_o", 64'(lock_o), 64'(el));
    if (chk_age)
      for (int p = 0; p < P; p++) chk("age", 64'(dut.r_age[p]), 64'(m_age[p]));
    model_commit(g, x);
    last_read = er;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; request_i = '0; ready_i = 1'b1; req0 = '0; ready0 = 1'b1;
    for (int p = 0; p < P; p++) begin in_flit[p] = '0; in_flit0[p] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  initial begin
    logic [FW-1:0] fa, fb, fc;
    logic [19:0]   fv;
    bit            pend [P];
    int            rem  [P];
    logic [FW-1:0] cur  [P];
    logic [1:0]    nt;

    //            rst  req       typ    fields     rdy  read      vld  src
    tbl[0]  = '{1'b1, 5'b01010, T_SGL, 20'h0C0A0, 1'b1, 5'b01000, 1'b0, -1};
    tbl[1]  = '{1'b0, 5'b00010, T_SGL, 20'h0C0A0, 1'b1, 5'b00010, 1'b1,  3};
    tbl[2]  = '{1'b0, 5'b00000, T_SGL, 20'h0C0A0, 1'b1, 5'b00000, 1'b1,  1};
    tbl[3]  = '{1'b0, 5'b00000, T_SGL, 20'h0C0A0, 1'b1, 5'b00000, 1'b0, -1};
    tbl[4]  = '{1'b1, 5'b10101, T_SGL, 20'h00000, 1'b1, 5'b00001, 1'b0, -1};
    tbl[5]  = '{1'b0, 5'b10101, T_SGL, 20'h00000, 1'b1, 5'b00100, 1'b1,  0};
    tbl[6]  = '{1'b0, 5'b10101, T_SGL, 20'h00000, 1'b1, 5'b10000, 1'b1,  2};
    tbl[7]  = '{1'b0, 5'b10101, T_SGL, 20'h00000, 1'b1, 5'b00001, 1'b1,  4};
    tbl[8]  = '{1'b0, 5'b00000, T_SGL, 20'h00000, 1'b1, 5'b00000, 1'b1,  0};
    tbl[9]  = '{1'b0, 5'b00000, T_SGL, 20'h00000, 1'b1, 5'b00000, 1'b0, -1};
    tbl[10] = '{1'b1, 5'b00101, T_SGL, 20'h0080B, 1'b1, 5'b00001, 1'b0, -1};
    tbl[11] = '{1'b0, 5'b00101, T_SGL, 20'h0080B, 1'b1, 5'b00001, 1'b1,  0};
    tbl[12] = '{1'b0, 5'b00101, T_SGL, 20'h0080B, 1'b1, 5'b00001, 1'b1,  0};
    tbl[13] = '{1'b0, 5'b00101, T_SGL, 20'h0080B, 1'b1, 5'b00100, 1'b1,  0};
    tbl[14] = '{1'b0, 5'b00001, T_SGL, 20'h0080B, 1'b1, 5'b00001, 1'b1,  2};
    tbl[15] = '{1'b0, 5'b00000, T_SGL, 20'h0080B, 1'b1, 5'b00000, 1'b1,  0};
    tbl[16] = '{1'b0, 5'b00000, T_SGL, 20'h0080B, 1'b1, 5'b00000, 1'b0, -1};

    // Reset state, with every input requesting
    ready_i = 1'b1; ready0 = 1'b1; req0 = '0; request_i = '1;
    for (int p = 0; p < P; p++) begin in_flit[p] = mk(T_SGL, 4'hF, p); in_flit0[p] = '0; end
    #1 rst_n = 1'b0;
    #6;
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_flit", 64'(flit_o), 64'(0));
    chk("rst_lock", 64'(lock_o), 64'(0));
    chk("rst_read", 64'(read_o), 64'(0));

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].do_rst) do_reset();
      request_i = tbl[i].req;
      ready_i   = tbl[i].rdy;
      fv        = tbl[i].fld;
      for (int p = 0; p < P; p++) in_flit[p] = mk(tbl[i].typ, fv[p*4 +: 4], p);
      @(negedge clk);
      chk("vec_read", 64'(read_o), 64'(tbl[i].e_read));
      chk("vec_valid", 64'(valid_o), 64'(tbl[i].e_valid));
      chk("vec_lock", 64'(lock_o), 64'(0));
      if (tbl[i].e_src >= 0)
        chk("vec_flit", 64'(flit_o), 64'(mk(tbl[i].typ, fv[tbl[i].e_src*4 +: 4], tbl[i].e_src)));
      tick();
    end

    // Tie-break-only aging cannot lift the weaker port over a stronger one
    do_reset();
    in_flit0[0] = mk(T_SGL, 4'hB, 0);
    in_flit0[2] = mk(T_SGL, 4'h8, 2);
    req0 = 5'b00101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("mode0_read", 64'(read0), 64'(5'b00001));
      tick();
    end
    req0 = '0;

    // Wormhole lock
    do_reset();
    in_flit[1] = mk(T_HDR, 4'h0, 'h11); request_i = 5'b00010;
    cycle(0); chk("wh_rd_h1", 64'(read_o), 64'(5'b00010)); tick();
    in_flit[1] = mk(T_PAY, 4'h0, 'h12); in_flit[0] = mk(T_HDR, 4'hF, 'h01); request_i = 5'b00011;
    cycle(0); chk("wh_lock_a", 64'(lock_o), 64'(5'b00010)); chk("wh_rd_p1", 64'(read_o), 64'(5'b00010));
    chk("wh_out_h1", 64'(flit_o), 64'(mk(T_HDR, 4'h0, 'h11))); tick();
    in_flit[1] = mk(T_LAST, 4'h0, 'h13);
    cycle(0); chk("wh_lock_b", 64'(lock_o), 64'(5'b00010)); chk("wh_rd_l1", 64'(read_o), 64'(5'b00010));
    chk("wh_out_p1", 64'(flit_o), 64'(mk(T_PAY, 4'h0, 'h12))); tick();
    request_i = 5'b00001;
    cycle(0); chk("wh_unlock", 64'(lock_o), 64'(0)); chk("wh_rd_h0", 64'(read_o), 64'(5'b00001));
    chk("wh_out_l1", 64'(flit_o), 64'(mk(T_LAST, 4'h0, 'h13))); tick();
    in_flit[0] = mk(T_LAST, 4'h0, 'h02);
    cycle(0); chk("wh_out_h0", 64'(flit_o), 64'(mk(T_HDR, 4'hF, 'h01))); chk("wh_lock_p0", 64'(lock_o), 64'(5'b00001)); tick();
    request_i = '0;
    cycle(0); tick();

    // Backpressure and back-to-back refill
    do_reset();
    fa = mk(T_SGL, 4'h0, 'h51); fb = mk(T_SGL, 4'h0, 'h52); fc = mk(T_SGL, 4'h0, 'h53);
    in_flit[0] = fa; request_i = 5'b00001;
    cycle(0); tick();
    in_flit[0] = fb; ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(0); chk("bp_flit", 64'(flit_o), 64'(fa)); chk("bp_read", 64'(read_o), 64'(0)); tick();
    end
    ready_i = 1'b1;
    cycle(0); chk("bp_resume", 64'(read_o), 64'(5'b00001)); tick();
    in_flit[0] = fc;
    cycle(0); chk("bp_b2b_rd", 64'(read_o), 64'(5'b00001)); chk("bp_b2b_flit", 64'(flit_o), 64'(fb)); tick();
    request_i = '0;
    cycle(0); chk("bp_last_flit", 64'(flit_o), 64'(fc)); chk("bp_last_vld", 64'(valid_o), 64'(1)); tick();
    cycle(0); tick();

    // Reset in the middle of a packet
    do_reset();
    in_flit[2] = mk(T_HDR, 4'h0, 'h61); request_i = 5'b00100;
    cycle(0); tick();
    in_flit[2] = mk(T_PAY, 4'h0, 'h62);
    chk("mr_lock_pre", 64'(lock_o), 64'(5'b00100));
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(valid_o), 64'(0));
    chk("mr_lock", 64'(lock_o), 64'(0));
    chk("mr_read", 64'(read_o), 64'(0));
    request_i = '0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    model_reset();
    in_flit[4] = mk(T_SGL, 4'h9, 'h64); request_i = 5'b10100;
    cycle(0); chk("mr_p4", 64'(read_o), 64'(5'b10000)); tick();
    request_i = 5'b00100;
    cycle(0); tick();
    request_i = '0;
    cycle(0); tick();

    // Random packet traffic against the model
    do_reset();
    for (int p = 0; p < P; p++) begin pend[p] = 1'b0; rem[p] = 0; cur[p] = '0; end
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < P; p++) begin
        if (!pend[p] && ($urandom % 3 == 0)) begin
          if (rem[p] > 0) begin
            rem[p]--;
            nt = (rem[p] == 0) ? T_LAST : T_PAY;
          end else if ($urandom % 2 == 0) begin
            nt = T_SGL;
          end else begin
            nt = T_HDR;
            rem[p] = int'($urandom_range(1, 3));
          end
          cur[p]  = mk(nt, 4'($urandom), c);
          pend[p] = 1'b1;
        end
        in_flit[p]   = cur[p];
        request_i[p] = pend[p] && ($urandom % 8 != 0);
      end
      ready_i = ($urandom % 4 != 0);
      cycle(1);
      for (int p = 0; p < P; p++) if (last_read[p]) pend[p] = 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
